// File: rtl/mux_n_1_pipe.sv
// N:1 word selector with a registered output stage and a 2-entry skid buffer.
// in_ready is a pure function of registered state, so out_ready never reaches the producer.
module mux_n_1_pipe #(
  parameter  int unsigned WIDTH    = 64,
  parameter  int unsigned NUM_IN   = 4,
  parameter  bit          OOR_ZERO = 1'b1,
  localparam int unsigned SEL_W    = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   main_data_q, main_data_d;
  logic [SEL_W-1:0]   main_sel_q, main_sel_d;
  logic [WIDTH-1:0]   skid_data_q, skid_data_d;
  logic [SEL_W-1:0]   skid_sel_q, skid_sel_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic               acc_c;
  logic               pop_c;
  logic [WIDTH-1:0]   sel_word_c;

  // Word selection; unmatched select values fall back to zero or word 0.
  always_comb begin
    sel_word_c = OOR_ZERO ? '0 : in_data[0 +: WIDTH];
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_word_c = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign acc_c = in_valid & in_ready_q;
  assign pop_c = out_valid_q & out_ready;

  // Next-state and datapath; the skid entry only ever moves into main, preserving order.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_sel_d  = main_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (acc_c) begin
          state_d     = ST_ONE;
          main_data_d = sel_word_c;
          main_sel_d  = sel;
        end
      end
      ST_ONE: begin
        if (acc_c && pop_c) begin
          main_data_d = sel_word_c;
          main_sel_d  = sel;
        end else if (acc_c) begin
          state_d     = ST_FULL;
          skid_data_d = sel_word_c;
          skid_sel_d  = sel;
        end else if (pop_c) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop_c) begin
          state_d     = ST_ONE;
          main_data_d = skid_data_q;
          main_sel_d  = skid_sel_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Flush discards everything, including a same-cycle accept; data may go stale.
    if (flush) begin
      state_d = ST_EMPTY;
    end

    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_sel_q  <= '0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_sel_q  <= main_sel_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_data_q;
  assign out_sel   = main_sel_q;

endmodule

// File: tb/tb_mux_n_1_pipe.sv
// Randomized check of mux_n_1_pipe (NUM_IN=5, both out-of-range modes) against a queue model.
module tb_mux_n_1_pipe;

  localparam int unsigned W  = 64;
  localparam int unsigned N  = 5;
  localparam int unsigned SW = 3;

  logic            clk;
  logic            reset_n;
  logic            flush;
  logic            in_valid;
  logic [SW-1:0]   sel;
  logic [N*W-1:0]  in_data;
  logic            out_ready;

  logic            z_in_ready, z_out_valid;
  logic [W-1:0]    z_out_data;
  logic [SW-1:0]   z_out_sel;
  logic            w_in_ready, w_out_valid;
  logic [W-1:0]    w_out_data;
  logic [SW-1:0]   w_out_sel;

  logic [W-1:0]    words [N];

  mux_n_1_pipe #(.WIDTH(W), .NUM_IN(N), .OOR_ZERO(1'b1)) dut_z (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(z_in_ready), .sel(sel), .in_data(in_data),
    .out_valid(z_out_valid), .out_ready(out_ready), .out_data(z_out_data), .out_sel(z_out_sel)
  );

  mux_n_1_pipe #(.WIDTH(W), .NUM_IN(N), .OOR_ZERO(1'b0)) dut_w (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(w_in_ready), .sel(sel), .in_data(in_data),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data), .out_sel(w_out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  dz;
    logic [W-1:0]  dw;
    logic [SW-1:0] s;
  } ent_t;

  ent_t q[$];
  bit   pristine;
  int   n_vec;
  int   n_mis;

  localparam logic [W-1:0] BASE = 64'h0123_4567_89AB_CDA0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic pack_words();
    for (int k = 0; k < N; k++) in_data[k*W +: W] = words[k];
  endtask

  task automatic std_words();
    for (int k = 0; k < N; k++) words[k] = BASE + W'(k);
    pack_words();
  endtask

  task automatic drive(input bit v, input int s, input bit ordy, input bit fl);
    in_valid  = v;
    sel       = SW'(s);
    out_ready = ordy;
    flush     = fl;
  endtask

  // Queue model: what the spec says each handshake must do.
  task automatic model_step();
    bit   acc, pop;
    ent_t e;
    acc = in_valid && (q.size() < 2);
    pop = (q.size() > 0) && out_ready;
    if (acc) pristine = 1'b0;
    e.s  = sel;
    e.dz = (int'(sel) < N) ? words[sel] : '0;
    e.dw = (int'(sel) < N) ? words[sel] : words[0];
    if (flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
  endtask

  task automatic check_all();
    chk("z_out_valid", W'(z_out_valid), W'(q.size() > 0));
    chk("z_in_ready",  W'(z_in_ready),  W'(q.size() < 2));
    chk("w_out_valid", W'(w_out_valid), W'(q.size() > 0));
    chk("w_in_ready",  W'(w_in_ready),  W'(q.size() < 2));
    if (q.size() > 0) begin
      chk("z_out_data", z_out_data, q[0].dz);
      chk("z_out_sel",  W'(z_out_sel), W'(q[0].s));
      chk("w_out_data", w_out_data, q[0].dw);
      chk("w_out_sel",  W'(w_out_sel), W'(q[0].s));
    end else if (pristine) begin
      chk("z_data_rst", z_out_data, '0);
      chk("z_sel_rst",  W'(z_out_sel), '0);
      chk("w_data_rst", w_out_data, '0);
      chk("w_sel_rst",  W'(w_out_sel), '0);
    end
  endtask

  // Called at a negedge with inputs already driven; ends at the following negedge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_z_valid"}, W'(z_out_valid), '0);
    chk({tag, "_z_ready"}, W'(z_in_ready), W'(1));
    chk({tag, "_z_data"},  z_out_data, '0);
    chk({tag, "_z_sel"},   W'(z_out_sel), '0);
    chk({tag, "_w_valid"}, W'(w_out_valid), '0);
    chk({tag, "_w_data"},  w_out_data, '0);
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear without an edge.
  task automatic pulse_reset();
    #1 reset_n = 1'b0;
    #1 check_reset_vals("async_rst");
    #1 reset_n = 1'b1;
    q.delete();
    pristine = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_mis = 0;
    reset_n = 1'b0;
    drive(0, 0, 0, 0);
    std_words();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    reset_n = 1'b1;
    q.delete();
    pristine = 1'b1;

    // Idle: nothing changes without in_valid.
    repeat (3) cycle();

    // Streaming 0..3 with out_ready high.
    for (int k = 0; k < 4; k++) begin
      drive(1, k, 1, 0);
      cycle();
      chk("stream_data", z_out_data, BASE + W'(k));
      chk("stream_sel",  W'(z_out_sel), W'(k));
      chk("stream_rdy",  W'(z_in_ready), W'(1));
    end
    drive(0, 0, 1, 0);
    cycle();

    // Backpressure: two accepts fill the buffer, then drain in order.
    drive(1, 2, 0, 0); cycle();
    drive(1, 3, 0, 0); cycle();
    chk("bp_full_rdy", W'(z_in_ready), '0);
    chk("bp_hold_d2",  z_out_data, BASE + W'(2));
    drive(0, 0, 0, 0); cycle();
    chk("bp_stable",   z_out_data, BASE + W'(2));
    drive(0, 0, 1, 0); cycle();
    chk("bp_drain_d3", z_out_data, BASE + W'(3));
    chk("bp_drain_rdy", W'(z_in_ready), W'(1));
    cycle();
    chk("bp_empty", W'(z_out_valid), '0);

    // Accept and pop together while holding one entry.
    drive(1, 0, 0, 0); cycle();
    drive(1, 1, 1, 0); cycle();
    chk("sim_valid", W'(z_out_valid), W'(1));
    chk("sim_data",  z_out_data, BASE + W'(1));

    // Out-of-range select.
    drive(1, 6, 1, 0); cycle();
    chk("oor_zero_data", z_out_data, '0);
    chk("oor_zero_sel",  W'(z_out_sel), W'(6));
    chk("oor_w0_data",   w_out_data, BASE);
    drive(0, 0, 1, 0); cycle();

    // Flush while full, with out_ready high.
    drive(1, 1, 0, 0); cycle();
    drive(1, 2, 0, 0); cycle();
    drive(1, 3, 1, 1); cycle();
    chk("flush_valid", W'(z_out_valid), '0);
    chk("flush_rdy",   W'(z_in_ready), W'(1));

    // Reset mid-operation while full.
    drive(1, 4, 0, 0); cycle();
    drive(1, 0, 0, 0); cycle();
    pulse_reset();
    drive(0, 0, 0, 0); cycle();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) words[k] = {$urandom, $urandom};
      pack_words();
      drive(($urandom_range(0, 9) < 7), int'($urandom_range(0, 7)),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 3));
      if ($urandom_range(0, 499) == 0) pulse_reset();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
